// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register write-bus arbiter and related
// shared-resource arbiters.
package reg_arb_pkg;

    typedef enum logic [0:0] {IDLE, XFER} arb_state_e;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned MAX_REGS   = 256;

    // Callers slice the low NUM_REGS bits; indices above that are never set.
    function automatic logic [MAX_REGS-1:0] onehot_decode(input logic [7:0] idx);
        logic [MAX_REGS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping past the top index back to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the shared register write bus: grant, one-cycle
// transfer with one-hot load strobe, ack back to the winner.
// Optional macro REG_WRITE_ARB_R0_PROTECT_EN makes register 0 read-only zero.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          bus_data,
    output logic [NUM_REGS-1:0]        load,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       addr_err
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REGS-1:0] load_q, load_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic                busy_q, busy_d;
    logic                addr_err_q, addr_err_d;

    logic                pick_valid;
    logic [ID_W-1:0]     pick_id;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                in_range;
    logic                r0_block;
    logic [MAX_REGS-1:0] addr_dec;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_comb begin
        win_addr = req_addr[pick_id*ADDR_W +: ADDR_W];
        win_data = req_data[pick_id*DATA_W +: DATA_W];
        in_range = (32'(win_addr) < NUM_REGS);
        addr_dec = onehot_decode(8'(win_addr));
`ifdef REG_WRITE_ARB_R0_PROTECT_EN
        r0_block = (win_addr == '0);
`else
        r0_block = 1'b0;
`endif
    end

    // Outputs are computed one edge early so they are registered in XFER.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        load_d     = '0;
        bus_data_d = '0;
        busy_d     = 1'b0;
        addr_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = XFER;
                    grant_id_d = pick_id;
                    ack_d      = NUM_REQ'(1) << pick_id;
                    bus_data_d = win_data;
                    busy_d     = 1'b1;
                    addr_err_d = !in_range;
                    if (in_range && !r0_block) begin
                        load_d = addr_dec[NUM_REGS-1:0];
                    end
                end
            end
            XFER: begin
                state_d = IDLE;
                ptr_d   = (32'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            load_q     <= '0;
            bus_data_q <= '0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            load_q     <= load_d;
            bus_data_q <= bus_data_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign ack      = ack_q;
    assign load     = load_q;
    assign bus_data = bus_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: default instance plus a NUM_REGS=6
// instance fed the same stimulus to exercise the out-of-range path.
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [63:0] req_data;

    logic [3:0]  ack,  ack6;
    logic [15:0] bus,  bus6;
    logic [7:0]  load;
    logic [5:0]  load6;
    logic [1:0]  gid,  gid6;
    logic        busy, busy6;
    logic        aerr, aerr6;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .bus_data (bus),
        .load     (load),
        .grant_id (gid),
        .busy     (busy),
        .addr_err (aerr)
    );

    reg_write_arbiter #(
        .NUM_REGS (6)
    ) u_dut6 (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack6),
        .bus_data (bus6),
        .load     (load6),
        .grant_id (gid6),
        .busy     (busy6),
        .addr_err (aerr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] addr;
        logic [63:0] data;
        logic [3:0]  e_ack;
        logic [7:0]  e_load;
        logic [15:0] e_bus;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] e_gid);
        chk({tag, " idle ack"},  32'(ack),  32'h0);
        chk({tag, " idle load"}, 32'(load), 32'h0);
        chk({tag, " idle bus"},  32'(bus),  32'h0);
        chk({tag, " idle busy"}, 32'(busy), 32'h0);
        chk({tag, " idle aerr"}, 32'(aerr), 32'h0);
        chk({tag, " idle gid"},  32'(gid),  32'(e_gid));
    endtask

    task automatic chk_xfer(input string tag, input logic [3:0] e_ack, input logic [7:0] e_load,
                            input logic [15:0] e_bus, input logic [1:0] e_gid);
        chk({tag, " ack"},  32'(ack),  32'(e_ack));
        chk({tag, " load"}, 32'(load), 32'(e_load));
        chk({tag, " bus"},  32'(bus),  32'(e_bus));
        chk({tag, " gid"},  32'(gid),  32'(e_gid));
        chk({tag, " busy"}, 32'(busy), 32'h1);
        chk({tag, " aerr"}, 32'(aerr), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r0_load;
`ifdef REG_WRITE_ARB_R0_PROTECT_EN
        r0_load = 8'b0000_0000;
`else
        r0_load = 8'b0000_0001;
`endif
        // Addresses in octal and data in hex: one digit/group per requester, 3 at the left.
        vecs[0] = '{4'b0100, 12'o0500, 64'h0000_BEEF_0000_0000, 4'b0100, 8'b0010_0000, 16'hBEEF, 2'd2};
        vecs[1] = '{4'b1001, 12'o1002, 64'h1111_0000_0000_2222, 4'b1000, 8'b0000_0010, 16'h1111, 2'd3};
        vecs[2] = '{4'b1001, 12'o1002, 64'h1111_0000_0000_2222, 4'b0001, 8'b0000_0100, 16'h2222, 2'd0};
        vecs[3] = '{4'b1111, 12'o4367, 64'hDDDD_CCCC_A5A5_BBBB, 4'b0010, 8'b0100_0000, 16'hA5A5, 2'd1};
        vecs[4] = '{4'b0011, 12'o4367, 64'hDDDD_CCCC_A5A5_BBBB, 4'b0001, 8'b1000_0000, 16'hBBBB, 2'd0};
        vecs[5] = '{4'b0010, 12'o0030, 64'h0000_0000_0001_0000, 4'b0010, 8'b0000_1000, 16'h0001, 2'd1};
        vecs[6] = '{4'b0100, 12'o0000, 64'h0000_1234_0000_0000, 4'b0100, r0_load,     16'h1234, 2'd2};

        req      = '0;
        req_addr = '0;
        req_data = '0;
        rst      = 1'b1;
        #2;
        chk_idle("reset", 2'd0);
        #10;
        rst = 1'b0;
        tick();
        chk_idle("post-reset", 2'd0);

        for (int i = 0; i < 7; i++) begin
            req      = vecs[i].req;
            req_addr = vecs[i].addr;
            req_data = vecs[i].data;
            tick();
            chk_xfer($sformatf("v%0d", i), vecs[i].e_ack, vecs[i].e_load, vecs[i].e_bus,
                     vecs[i].e_gid);
            req = '0;
            tick();
            chk_idle($sformatf("v%0d", i), vecs[i].e_gid);
        end

        // Out of range on the 6-register instance; pointer is 3 so requester 1 wins.
        req      = 4'b0010;
        req_addr = 12'o0070;
        req_data = 64'h0000_0000_CAFE_0000;
        tick();
        chk("oor ack6",  32'(ack6),  32'h2);
        chk("oor load6", 32'(load6), 32'h0);
        chk("oor aerr6", 32'(aerr6), 32'h1);
        chk("oor bus6",  32'(bus6),  32'hCAFE);
        chk("oor busy6", 32'(busy6), 32'h1);
        chk_xfer("oor main", 4'b0010, 8'b1000_0000, 16'hCAFE, 2'd1);
        req = '0;
        tick();
        chk("oor aerr6 drop", 32'(aerr6), 32'h0);
        chk("oor ack6 drop",  32'(ack6),  32'h0);

        // Reset mid-transfer: pointer 2 -> serve 2 -> pointer 3 -> requester 3 in flight.
        req      = 4'b0100;
        req_addr = 12'o0500;
        req_data = 64'h0000_5555_0000_0000;
        tick();
        chk_xfer("pre-rst", 4'b0100, 8'b0010_0000, 16'h5555, 2'd2);
        req = '0;
        tick();
        req      = 4'b1000;
        req_addr = 12'o4000;
        req_data = 64'h7777_0000_0000_0000;
        tick();
        chk_xfer("inflight", 4'b1000, 8'b0001_0000, 16'h7777, 2'd3);
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async rst", 2'd0);
        rst = 1'b0;
        // Pointer back at 0: requester 1 beats 3.
        req      = 4'b1010;
        req_addr = 12'o4010;
        req_data = 64'h7777_0000_0101_0000;
        tick();
        chk_xfer("after rst", 4'b0010, 8'b0000_0010, 16'h0101, 2'd1);
        req = 4'b1000;
        tick();
        chk_idle("after rst", 2'd1);
        tick();
        chk_xfer("after rst r3", 4'b1000, 8'b0001_0000, 16'h7777, 2'd3);
        req = '0;
        tick();
        chk_idle("after rst r3", 2'd3);

        // Full contention from reset: each requester holds until its own ack.
        do_reset();
        req      = 4'b1111;
        req_addr = 12'o4321;
        req_data = 64'h4444_3333_2222_1111;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] e_ack;
            logic [7:0] e_load;
            logic [15:0] e_bus;
            e_ack  = 4'b0001 << k;
            e_load = 8'b0000_0010 << k;
            e_bus  = 16'h1111 * 16'(k + 1);
            tick();
            chk_xfer($sformatf("cont%0d", k), e_ack, e_load, e_bus, 2'(k));
            req[k] = 1'b0;
            tick();
            chk_idle($sformatf("cont%0d", k), 2'(k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
